// File: rtl/if_fetch_queue_pkg.sv
// Shared widths and entry packing for the instruction fetch queue.
// An entry is packed as {pc, insn, predt} with predt in bit 0.
package if_fetch_queue_pkg;

   localparam int PC_WIDTH   = 32;
   localparam int WORD_WIDTH = 32;

   localparam int PREDT_LSB = 0;
   localparam int INSN_LSB  = 1;

   function automatic int pc_lsb(input int insn_w);
      return insn_w + 1;
   endfunction

   function automatic int entry_w(input int pc_w, input int insn_w);
      return pc_w + insn_w + 1;
   endfunction

endpackage

// File: rtl/if_fetch_queue_mem.sv
// Entry storage for the fetch queue: DEPTH x ENT_W registers,
// one write port, one asynchronous read port, data not reset.
module if_fetch_queue_mem
   import if_fetch_queue_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int ENT_W = entry_w(PC_WIDTH, WORD_WIDTH),
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [PTR_W-1:0] waddr,
   input  logic [ENT_W-1:0] wdata,
   input  logic [PTR_W-1:0] raddr,
   output logic [ENT_W-1:0] rdata
);

   logic [ENT_W-1:0] mem_q [DEPTH];
   logic [ENT_W-1:0] mem_d [DEPTH];

   always_comb begin
      mem_d = mem_q;
      if (we) begin
         mem_d[waddr] = wdata;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/if_fetch_queue.sv
// Fetch buffer between IF and ID: pending request slot plus a DEPTH-entry FIFO.
// Optional IF_FETCH_QUEUE_BYPASS_EN lets a returning insn reach decode while the queue is empty.
module if_fetch_queue
   import if_fetch_queue_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int PC_W   = PC_WIDTH,
   parameter int INSN_W = WORD_WIDTH
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         cpu_en,
   input  logic                         if_flush,
   input  logic                         req_valid,
   input  logic [PC_W-1:0]              req_pc,
   input  logic                         req_predt_br_taken,
   output logic                         req_ready,
   input  logic [INSN_W-1:0]            insn,
   input  logic                         id_ready,
   output logic                         if_en,
   output logic [PC_W-1:0]              if_pc,
   output logic [INSN_W-1:0]            if_insn,
   output logic                         if_predt_br_taken,
   output logic [$clog2(DEPTH+1)-1:0]   if_count
);

   localparam int PTR_W  = $clog2(DEPTH);
   localparam int CNT_W  = $clog2(DEPTH+1);
   localparam int ENT_W  = entry_w(PC_W, INSN_W);
   localparam int PC_LSB = pc_lsb(INSN_W);

   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              pend_v_q, pend_v_d;
   logic [PC_W-1:0]   pend_pc_q, pend_pc_d;
   logic              pend_predt_q, pend_predt_d;

   logic              empty;
   logic              accept;
   logic              pop;
   logic              byp_act;
   logic              wr_en;
   logic              rd_en;
   logic [ENT_W-1:0]  wr_data;
   logic [ENT_W-1:0]  rd_data;

   assign empty = (count_q == '0);

   // Credit check counts the pending slot so its write always finds room.
   assign req_ready = cpu_en &
      (({1'b0, count_q} + {{CNT_W{1'b0}}, pend_v_q}) < (CNT_W+1)'(DEPTH));
   assign accept = req_valid & req_ready & ~if_flush;

`ifdef IF_FETCH_QUEUE_BYPASS_EN
   assign byp_act = empty & pend_v_q;
`else
   assign byp_act = 1'b0;
`endif

   always_comb begin
      if_en             = 1'b0;
      if_pc             = '0;
      if_insn           = '0;
      if_predt_br_taken = 1'b0;
      if (byp_act) begin
         if_en             = 1'b1;
         if_pc             = pend_pc_q;
         if_insn           = insn;
         if_predt_br_taken = pend_predt_q;
      end else if (!empty) begin
         if_en             = 1'b1;
         if_pc             = rd_data[PC_LSB +: PC_W];
         if_insn           = rd_data[INSN_LSB +: INSN_W];
         if_predt_br_taken = rd_data[PREDT_LSB];
      end
   end

   assign pop     = if_en & id_ready & cpu_en;
   assign rd_en   = pop & ~empty;
   // A bypassed entry consumed on arrival never enters storage.
   assign wr_en   = pend_v_q & ~(byp_act & pop) & ~if_flush;
   assign wr_data = {pend_pc_q, insn, pend_predt_q};

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      pend_v_d = 1'b0;
      if (if_flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         end
         if (rd_en) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         count_d  = count_q + CNT_W'(wr_en) - CNT_W'(rd_en);
         pend_v_d = accept;
      end
   end

   always_comb begin
      pend_pc_d    = pend_pc_q;
      pend_predt_d = pend_predt_q;
      if (accept) begin
         pend_pc_d    = req_pc;
         pend_predt_d = req_predt_br_taken;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         pend_v_q <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         pend_v_q <= pend_v_d;
      end
   end

   always_ff @(posedge clk) begin
      pend_pc_q    <= pend_pc_d;
      pend_predt_q <= pend_predt_d;
   end

   if_fetch_queue_mem #(
      .DEPTH (DEPTH),
      .ENT_W (ENT_W),
      .PTR_W (PTR_W)
   ) u_mem (
      .clk   (clk),
      .we    (wr_en),
      .waddr (wr_ptr_q),
      .wdata (wr_data),
      .raddr (rd_ptr_q),
      .rdata (rd_data)
   );

   assign if_count = count_q;

endmodule

// File: tb/tb_if_fetch_queue.sv
// Scoreboard bench for if_fetch_queue: directed scenarios then randomized traffic.
module tb_if_fetch_queue;

   localparam int DEPTH  = 4;
   localparam int PC_W   = 32;
   localparam int INSN_W = 32;
   localparam int CNT_W  = $clog2(DEPTH+1);
`ifdef IF_FETCH_QUEUE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst_n;
   logic              cpu_en;
   logic              if_flush;
   logic              req_valid;
   logic [PC_W-1:0]   req_pc;
   logic              req_predt_br_taken;
   logic              req_ready;
   logic [INSN_W-1:0] insn;
   logic              id_ready;
   logic              if_en;
   logic [PC_W-1:0]   if_pc;
   logic [INSN_W-1:0] if_insn;
   logic              if_predt_br_taken;
   logic [CNT_W-1:0]  if_count;

   if_fetch_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .INSN_W(INSN_W)) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .cpu_en             (cpu_en),
      .if_flush           (if_flush),
      .req_valid          (req_valid),
      .req_pc             (req_pc),
      .req_predt_br_taken (req_predt_br_taken),
      .req_ready          (req_ready),
      .insn               (insn),
      .id_ready           (id_ready),
      .if_en              (if_en),
      .if_pc              (if_pc),
      .if_insn            (if_insn),
      .if_predt_br_taken  (if_predt_br_taken),
      .if_count           (if_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [PC_W-1:0]   pc;
      logic [INSN_W-1:0] insn;
      logic              predt;
   } ent_t;

   // Reference: entries held in storage, in order, plus the one-deep pending request.
   ent_t sb[$];
   ent_t m_pend_e;
   bit   m_pend;
   bit   m_byp_popped;
   bit   exp_ready;
   bit   in_reset;
   int   checks   = 0;
   int   failures = 0;
   int   pops     = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Monitor: compares the presented head and consumes it on each handshake.
   ent_t head;
   bit   have_head;
   always @(negedge clk) begin
      if (rst_n && !in_reset) begin
         have_head = (sb.size() != 0) || (BYP && m_pend);
         head      = (sb.size() != 0) ? sb[0] : m_pend_e;
         check("if_en", 64'(if_en), 64'(have_head));
         check("if_count", 64'(if_count), 64'(sb.size()));
         check("req_ready", 64'(req_ready), 64'(exp_ready));
         if (have_head) begin
            check("head_pc", 64'(if_pc), 64'(head.pc));
            check("head_insn", 64'(if_insn), 64'(head.insn));
            check("head_predt", 64'(if_predt_br_taken), 64'(head.predt));
         end else begin
            check("empty_zero", {if_pc, if_insn} | 64'(if_predt_br_taken), 64'd0);
         end
         if (if_en && id_ready && cpu_en) begin
            pops++;
            if (sb.size() != 0) void'(sb.pop_front());
            else if (BYP && m_pend) m_byp_popped = 1'b1;
         end
      end
   end

   // One clock cycle of stimulus; the model advances after the edge.
   task automatic step(input bit v, input logic [PC_W-1:0] pc, input bit pr,
                       input bit idr, input bit en, input bit fl);
      logic [INSN_W-1:0] new_insn;
      bit acc;
      req_valid          = v;
      req_pc             = pc;
      req_predt_br_taken = pr;
      id_ready           = idr;
      cpu_en             = en;
      if_flush           = fl;
      exp_ready          = en && ((sb.size() + int'(m_pend)) < DEPTH);
      acc                = v && exp_ready && !fl;
      new_insn           = $urandom;
      @(posedge clk);
      #1;
      if (fl) begin
         sb.delete();
         m_pend = 1'b0;
      end else begin
         if (m_pend && !m_byp_popped) sb.push_back(m_pend_e);
         m_pend = acc;
         if (acc) begin
            m_pend_e.pc    = pc;
            m_pend_e.insn  = new_insn;
            m_pend_e.predt = pr;
         end
      end
      m_byp_popped = 1'b0;
      insn = m_pend ? m_pend_e.insn : INSN_W'($urandom);
   endtask

   task automatic do_reset();
      cpu_en    = 1'b0;
      req_valid = 1'b0;
      id_ready  = 1'b0;
      if_flush  = 1'b0;
      in_reset  = 1'b1;
      rst_n     = 1'b0;
      sb.delete();
      m_pend       = 1'b0;
      m_byp_popped = 1'b0;
      exp_ready    = 1'b0;
      #1;
      check("rst_if_en", 64'(if_en), 64'd0);
      check("rst_if_count", 64'(if_count), 64'd0);
      check("rst_req_ready", 64'(req_ready), 64'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n    = 1'b1;
      in_reset = 1'b0;
   endtask

   logic [PC_W-1:0] rpc;

   initial begin
      insn               = '0;
      req_pc             = '0;
      req_predt_br_taken = 1'b0;
      do_reset();
      step(0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);

      // Four back-to-back requests while decode stalls; credits stop further accepts.
      step(1, 32'h0, 1, 0, 1, 0);
      step(1, 32'h4, 0, 0, 1, 0);
      step(1, 32'h8, 1, 0, 1, 0);
      step(1, 32'hC, 0, 0, 1, 0);
      step(1, 32'h10, 1, 0, 1, 0);
      step(1, 32'h14, 1, 0, 1, 0);
      check("full_count", 64'(if_count), 64'(DEPTH));
      repeat (6) step(0, 0, 0, 1, 1, 0);

      // Flush in the cycle after a request drops its return; a fresh request follows.
      step(1, 32'h10, 0, 0, 1, 0);
      step(0, 0, 0, 0, 1, 1);
      step(1, 32'h40, 1, 0, 1, 0);
      step(0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 1, 1, 0);
      step(0, 0, 0, 1, 1, 0);

      // Sustained write and pop, wrapping the pointers several times.
      for (int i = 0; i < 5; i++) step(1, PC_W'(32'h100 + 4*i), i[0], 0, 1, 0);
      for (int i = 0; i < 12; i++) step(1, PC_W'(32'h200 + 4*i), i[1], 1, 1, 0);
      repeat (3) step(0, 0, 0, 1, 1, 0);

      // cpu_en low with a request pending: it still lands, nothing pops.
      step(1, 32'h300, 1, 1, 1, 0);
      step(1, 32'h304, 0, 1, 0, 0);
      step(0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 1, 1, 0);
      step(0, 0, 0, 1, 1, 0);

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         rpc = PC_W'($urandom) & ~PC_W'(3);
         step($urandom_range(0, 3) != 0, rpc, 1'($urandom), $urandom_range(0, 2) != 0,
              $urandom_range(0, 7) != 0, $urandom_range(0, 24) == 0);
      end

      // Reset with three entries queued.
      repeat (3) step(0, 0, 0, 1, 1, 0);
      step(1, 32'h500, 0, 0, 1, 0);
      step(1, 32'h504, 1, 0, 1, 0);
      step(1, 32'h508, 0, 0, 1, 0);
      step(0, 0, 0, 0, 1, 0);
      check("pre_reset_count", 64'(if_count), 64'd3);
      do_reset();
      step(0, 0, 0, 1, 0, 0);
      step(1, 32'h600, 1, 1, 1, 0);
      repeat (4) step(0, 0, 0, 1, 1, 0);

      check("pops_seen", 64'(pops > 20), 64'd1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
